// File: rtl/code_run_logger_if.sv
// Run-length logger bus: sample/flush inputs and
// valid/ready entry output with FIFO status.
interface code_run_logger_if #(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4
);
  logic                   en;
  logic [CODE_W-1:0]      code_in;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [CODE_W-1:0]      out_code;
  logic [CNT_W-1:0]       out_len;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport master (
    output en, code_in, flush, out_ready,
    input  out_valid, out_code, out_len,
    input  count, overflow
  );

  modport slave (
    input  en, code_in, flush, out_ready,
    output out_valid, out_code, out_len,
    output count, overflow
  );
endinterface

// File: rtl/code_run_logger.sv
// Compresses a sampled code stream into (code, length)
// runs and queues them in a small FIFO for a consumer.
module code_run_logger #(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic rst,
  code_run_logger_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CODE_W-1:0] r_cur_code;
  logic [CNT_W-1:0]  r_run_len;
  logic              r_run_open;

  logic [CODE_W-1:0] r_mem_code [DEPTH];
  logic [CNT_W-1:0]  r_mem_len  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;

  logic w_same;
  logic w_at_max;
  logic w_close_flush;
  logic w_close_en;
  logic w_push;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_same   = bus.code_in == r_cur_code;
  assign w_at_max = r_run_len == MAX;

  // A flush wins over an en-driven close, so a
  // cycle never closes more than one run.
  assign w_close_flush = bus.flush && r_run_open;
  assign w_close_en    = bus.en && r_run_open &&
                         (!w_same || w_at_max);
  assign w_push        = w_close_flush || w_close_en;

  assign w_valid = r_count != '0;
  assign w_full  = r_count == CW'(DEPTH);
  assign w_pop   = w_valid && bus.out_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Run tracker: a new sample restarts at 1 after
  // any close, so saturated runs split, never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_code <= '0;
      r_run_len  <= '0;
      r_run_open <= 1'b0;
    end else if (bus.en) begin
      r_cur_code <= bus.code_in;
      r_run_open <= 1'b1;
      if (w_push || !r_run_open) begin
        r_run_len <= CNT_W'(1);
      end else begin
        r_run_len <= r_run_len + CNT_W'(1);
      end
    end else if (bus.flush) begin
      r_run_open <= 1'b0;
    end
  end

  // Entry storage; a full-FIFO write with a pop
  // lands in the slot being vacated this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_code[i] <= '0;
        r_mem_len[i]  <= '0;
      end
    end else if (w_wr) begin
      r_mem_code[r_wr_ptr] <= r_cur_code;
      r_mem_len[r_wr_ptr]  <= r_run_len;
    end
  end

  // Pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_code  = w_valid ?
                         r_mem_code[r_rd_ptr] : '0;
  assign bus.out_len   = w_valid ?
                         r_mem_len[r_rd_ptr] : '0;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_code_run_logger.sv
// Directed bench for code_run_logger: vector table
// plus hand sequences for saturation, full and reset.
module tb_code_run_logger;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  code_run_logger_if bus ();

  code_run_logger dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] code;
    logic       flush;
    logic       ready;
    logic       valid;
    logic [2:0] ecode;
    logic [7:0] elen;
    logic [2:0] ecount;
    logic       eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int en, input int code, input int fl,
    input int rdy, input int vld, input int ec,
    input int el, input int cnt, input int ovf
  );
    vec_t v;
    v.en     = 1'(en);
    v.code   = 3'(code);
    v.flush  = 1'(fl);
    v.ready  = 1'(rdy);
    v.valid  = 1'(vld);
    v.ecode  = 3'(ec);
    v.elen   = 8'(el);
    v.ecount = 3'(cnt);
    v.eovf   = 1'(ovf);
    return v;
  endfunction

  task automatic chk(
    input string name, input int act, input int exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input int en, input int code,
    input int fl, input int rdy
  );
    bus.en        = 1'(en);
    bus.code_in   = 3'(code);
    bus.flush     = 1'(fl);
    bus.out_ready = 1'(rdy);
  endtask

  task automatic head(
    input string name, input int c, input int l
  );
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_code"}, int'(bus.out_code), c);
    chk({name, "_len"}, int'(bus.out_len), l);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_code", int'(bus.out_code), 0);
    chk("rst_len", int'(bus.out_len), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0);

    // 1: runs 5x3, 4x2, flush
    tbl.push_back(mk(1,5,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,5,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,5,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,4,0,1, 1,5,3,1,0));
    tbl.push_back(mk(1,4,0,1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1, 1,4,2,1,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));
    // 3: alternate 1,2 with ready low
    tbl.push_back(mk(1,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,2,0,0, 1,1,1,1,0));
    tbl.push_back(mk(1,1,0,0, 1,1,1,2,0));
    tbl.push_back(mk(1,2,0,0, 1,1,1,3,0));
    tbl.push_back(mk(1,1,0,0, 1,1,1,4,0));
    tbl.push_back(mk(1,2,0,0, 1,1,1,4,1));
    tbl.push_back(mk(0,0,0,1, 1,2,1,3,1));
    tbl.push_back(mk(0,0,0,1, 1,1,1,2,1));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1,1));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,2,1,1,1));
    // 5: gaps, then flush with en
    tbl.push_back(mk(1,6,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,6,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,6,0,1, 0,0,0,0,1));
    tbl.push_back(mk(1,6,0,1, 0,0,0,0,1));
    tbl.push_back(mk(1,6,0,1, 0,0,0,0,1));
    tbl.push_back(mk(1,2,0,1, 1,6,3,1,1));
    tbl.push_back(mk(1,7,1,1, 1,2,1,1,1));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1, 1,7,1,1,1));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,1));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      drive(tbl[i].en, tbl[i].code,
            tbl[i].flush, tbl[i].ready);
      step();
      chk({n, "_valid"}, int'(bus.out_valid),
          int'(tbl[i].valid));
      chk({n, "_count"}, int'(bus.count),
          int'(tbl[i].ecount));
      chk({n, "_ovf"}, int'(bus.overflow),
          int'(tbl[i].eovf));
      if (tbl[i].valid) begin
        chk({n, "_code"}, int'(bus.out_code),
            int'(tbl[i].ecode));
        chk({n, "_len"}, int'(bus.out_len),
            int'(tbl[i].elen));
      end
    end

    // 2: saturation at 255, no wrap to 0
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1, 0, 0, 0);
      step();
      if (i == 255) chk("sat255_count",
                        int'(bus.count), 0);
      if (i == 256) begin
        chk("sat256_count", int'(bus.count), 1);
        head("sat256", 0, 255);
      end
    end
    drive(1, 3, 0, 0);
    step();
    chk("sat_close_count", int'(bus.count), 2);
    head("sat_close", 0, 255);
    drive(0, 0, 0, 1);
    step();
    chk("sat_pop1_count", int'(bus.count), 1);
    head("sat_pop1", 0, 45);
    step();
    chk("sat_pop2_count", int'(bus.count), 0);
    drive(0, 0, 1, 1);
    step();
    head("sat_open3", 3, 1);
    drive(0, 0, 0, 1);
    step();
    chk("sat_end_count", int'(bus.count), 0);

    // 4: full FIFO with push and pop together
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, (i % 2 == 0) ? 1 : 2, 0, 0);
      step();
    end
    chk("full_count", int'(bus.count), 4);
    chk("full_ovf", int'(bus.overflow), 0);
    drive(1, 2, 0, 1);
    step();
    chk("pp_count", int'(bus.count), 4);
    chk("pp_ovf", int'(bus.overflow), 0);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      head($sformatf("pp_head%0d", k),
           (k % 2 == 0) ? 2 : 1, 1);
      step();
      chk($sformatf("pp_drain%0d", k),
          int'(bus.count), 3 - k);
    end
    chk("pp_end_ovf", int'(bus.overflow), 0);

    // 6: async reset mid-run with entries queued
    do_reset();
    drive(1, 1, 0, 0);
    step();
    drive(1, 2, 0, 0);
    step();
    drive(1, 3, 0, 0);
    step();
    chk("pre_rst_count", int'(bus.count), 2);
    rst = 1'b0;
    #1;
    chk("async_valid", int'(bus.out_valid), 0);
    chk("async_count", int'(bus.count), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 1);
    step();
    chk("post_rst_flush_count", int'(bus.count), 0);
    chk("post_rst_flush_valid",
        int'(bus.out_valid), 0);
    drive(0, 0, 0, 1);
    step();
    chk("post_rst_idle_count", int'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
